// File: rtl/multipath_equalizer_pkg.sv
// Shared definitions for the voice channel chain.
// Holds the sample width, the equalizer state type and the
// saturate-to-8 helper. The channel model and the equalizer both use them.
package multipath_equalizer_pkg;

  localparam int unsigned SAMPLE_W = 8;
  // Wide enough for (4*y - x) with y and x in -128..127: -639..636
  localparam int unsigned ACC_W    = 11;

  typedef enum logic [1:0] {
    EQ_IDLE  = 2'd0,
    EQ_PRIME = 2'd1,
    EQ_RUN   = 2'd2
  } eq_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > 11'sd127)
      return 8'sd127;
    else if (v < -11'sd128)
      return -8'sd128;
    else
      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/multipath_equalizer_sat8.sv
// eq_sat8: combinational 11-bit to 8-bit signed saturator.
// Ports:
//   din   in   11-bit signed value
//   dout  out  value clamped to -128..127
//   clip  out  high when din lay outside -128..127
module eq_sat8
  import multipath_equalizer_pkg::*;
(
  input  logic signed [ACC_W-1:0]    din,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       clip
);

  always_comb begin
    dout = sat8(din);
    clip = (din > 11'sd127) || (din < -11'sd128);
  end

endmodule

// File: rtl/multipath_equalizer.sv
// multipath_equalizer: decision-feedback inverse of the two-path
// attenuating channel y[n] = ((x[n-1]>>>1) + (x[n-2]>>>1))>>>1.
// Recovers x[k] = sat8(4*y[k+1] - x[k-1]) per frame; y[0] of each frame
// carries no information and is dropped.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_sof      channel sample and start-of-frame marker
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   out_data/out_sof    recovered sample, first-of-frame marker
//   out_valid/out_ready output handshake, single register, no skid
//   sat_count           saturating count of clipped outputs
//   frame_err           one-cycle pulse on misplaced or missing sof
module multipath_equalizer
  import multipath_equalizer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned SAT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAT_W-1:0] sat_count,
  output logic             frame_err
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  eq_state_t                  state, state_nxt;
  logic [15:0]                cnt, cnt_nxt;
  logic signed [SAMPLE_W-1:0] hist, hist_nxt;
  logic signed [ACC_W-1:0]    acc_val;
  logic signed [SAMPLE_W-1:0] sat_val;
  logic                       clip;
  logic                       accept;
  logic                       emit;
  logic                       emit_sof;
  logic                       err_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // 4*y built by concatenation keeps the sign bit without a shift overflow
  assign acc_val = $signed({in_data[7], in_data, 2'b00})
                 - $signed({{3{hist[7]}}, hist});

  eq_sat8 u_sat (
    .din  (acc_val),
    .dout (sat_val),
    .clip (clip)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EQ_IDLE;
      cnt   <= '0;
      hist  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hist  <= hist_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hist_nxt  = hist;
    emit      = 1'b0;
    emit_sof  = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      case (state)
        EQ_IDLE: begin
          if (in_sof) begin
            state_nxt = EQ_PRIME;
            cnt_nxt   = 16'd1;
            hist_nxt  = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        EQ_PRIME, EQ_RUN: begin
          if (in_sof) begin
            // Misplaced sof: report it and treat this beat as the new y[0]
            err_nxt   = 1'b1;
            state_nxt = EQ_PRIME;
            cnt_nxt   = 16'd1;
            hist_nxt  = '0;
          end else begin
            emit     = 1'b1;
            emit_sof = (state == EQ_PRIME);
            hist_nxt = sat_val;
            // PRIME can also hold the last beat when FRAME_LEN is 2
            if (cnt == LAST_IDX) begin
              state_nxt = EQ_IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = EQ_RUN;
              cnt_nxt   = cnt + 16'd1;
            end
          end
        end
        default: state_nxt = EQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      frame_err <= 1'b0;
      sat_count <= '0;
    end else begin
      frame_err <= err_nxt;
      // Discarded beats still free the output register when it is consumed
      if (in_ready) begin
        out_valid <= emit;
        out_sof   <= emit_sof;
        if (emit)
          out_data <= sat_val;
      end
      if (emit && clip && (sat_count != '1))
        sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: doc/multipath_equalizer.md
# multipath_equalizer

Receive-side inverse of the two-path attenuating channel. It recovers transmitted 8-bit voice samples from the channel output stream by decision-feedback cancellation of the second path. It sits between the channel model output and the voice decoder in the simulation chain. It is frame-based: path history is cleared at every start-of-frame, and samples flow through valid/ready handshakes.

## Interface
- FRAME_LEN, 256, channel samples per frame, including the leading all-echo sample; range 2..65535
- SAT_W, 16, width of the saturation event counter
- clk  in  1  sole clock; everything is rising-edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  8  signed channel sample y[n]
- in_sof  in  1  marks the first sample of a frame; sampled only on an accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  equalizer can accept a beat
- out_data  out  8  signed recovered sample x̂[k]
- out_sof  out  1  first recovered sample of a frame
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- sat_count  out  SAT_W  saturating count of clipped outputs since reset
- frame_err  out  1  one-cycle pulse when an in_sof arrives mid-frame, or data arrives in IDLE without in_sof

## Operation
- Channel model being inverted: y[n] = ((x[n-1]>>>1) + (x[n-2]>>>1))>>>1, with x[-1] = x[-2] = 0 at frame start.
- Recovery rule: x̂[k] = sat8((y[k+1] <<< 2) − x̂[k-1]), with x̂[-1] = 0.
  - Compute in 11-bit signed, then saturate to −128..127.
  - Each clip increments sat_count; sat_count holds at all-ones.
  - The feedback term uses the saturated value.
- FSM with three states:
  - IDLE
    - Accepted beat with in_sof → PRIME.
    - Accepted beat without in_sof → discard it and pulse frame_err.
  - PRIME
    - Set the history register to 0 and the sample counter to 1 on entry.
    - The first sample y[0] carries no x information and is discarded; no output.
    - Next accepted beat → RUN and produce x̂[0] with out_sof = 1.
  - RUN
    - Each accepted beat produces one output and increments the counter.
    - When the counter reaches FRAME_LEN−1 and that beat is accepted → IDLE.
    - An accepted in_sof in RUN pulses frame_err and restarts the frame as PRIME; the beat is treated as the new y[0].
- Each frame yields FRAME_LEN−1 outputs. Only the first carries out_sof.
- Handshake uses a single output register with no skid: in_ready = !out_valid || out_ready.
  - Beats are accepted in all states under this rule.
  - Discarded beats (PRIME, IDLE) are accepted when in_ready is high.
- out_data holds stable while out_valid && !out_ready.

## Timing
- Latency is one cycle: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput is 1 sample/cycle when out_ready is held high.
- Reset values: out_valid 0, out_data 0, out_sof 0, frame_err 0, sat_count 0, FSM IDLE, history 0, counter 0. in_ready is 1 after reset.
- Reset asserted mid-frame aborts the frame. The pending output is dropped and no partial-frame state survives.
- Simultaneous events:
  - Output consumed and new beat accepted in the same cycle: out_valid stays 1 and out_data is replaced.
  - Frame's last beat accepted together with an in_sof on the next cycle: handled as IDLE→PRIME, with no frame_err.
- frame_err is registered: it rises the cycle after the offending beat and lasts one cycle.

## Structure
- A shared package (e.g. `voice_chan_pkg`) holds the sample width constant (8), the equalizer state enum (IDLE/PRIME/RUN), and the saturate-to-8 function. The channel model and later blocks reuse them.
- One sub-module is natural: `eq_sat8`, the combinational 11→8 saturator with a clip flag.
- The FSM, counter, history, and handshake live in the top module.

## Test plan
- Basic frame: FRAME_LEN=5; in y = 0(sof),16,24,4,−2, out_ready=1 → out 64(sof),32,−16,8 on consecutive cycles; sat_count=0.
- Saturation: frame y = 0(sof),127,−128 → out 127, then −128 (−512−127 clipped); sat_count=2.
- Backpressure: same stimulus as the basic frame, with out_ready low for 3 cycles after the first output → out_data holds 64, in_ready=0 during the stall, then 32,−16,8 with no loss or duplication.
- Mid-frame sof: FRAME_LEN=5; y = 0(sof),16,24, then 0(sof),16,24,4,−2 → outputs 64,32, then frame_err pulse, then 64(sof),32,−16,8.
- IDLE garbage, then reset mid-frame:
  - 2 beats without sof while in IDLE → two frame_err pulses, no outputs.
  - rst_n=0 for 1 cycle during RUN → all outputs at reset values.
  - The next frame decodes as in the basic-frame case.
- Back-to-back frames: two 5-sample frames with no gap → 8 outputs, sof on the 1st and 5th, no frame_err.
